// File: rtl/spi_host_driver.sv
// SPI initiator: turns an address plus a burst of data bytes into LSB-first sclk/pico
// frames, captures poci into rd_data, and holds sclk low for a gap after each frame.
module spi_host_driver #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16,
    parameter int STALL_MAX  = 8
) (
    input  logic       iclk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_addr,
    input  logic [3:0] cmd_len,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       err_abort,
    output logic       busy,
    output logic       sclk,
    output logic       pico,
    input  logic       poci
);

    localparam int PW = (CLK_DIV > 1)    ? $clog2(CLK_DIV)    : 1;
    localparam int SW = (STALL_MAX > 1)  ? $clog2(STALL_MAX)  : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [SW-1:0] STL_LAST = SW'(STALL_MAX - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_DATA, GAP} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] phase;
    logic          high;
    logic [2:0]    bit_idx;
    logic [3:0]    remaining;
    logic          is_data;
    logic [6:0]    tx;
    logic [6:0]    rx;
    logic [SW-1:0] stall_cnt;
    logic [GW-1:0] gap_cnt;
    logic          byte_end;

    assign byte_end = high && (phase == PH_LAST) && (bit_idx == 3'd7);

    always_ff @(posedge iclk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (cmd_valid) state_nxt = SHIFT;
            SHIFT:     if (byte_end) state_nxt = (remaining != 4'd0) ? WAIT_DATA : GAP;
            WAIT_DATA: begin
                if (wr_valid)                    state_nxt = SHIFT;
                else if (stall_cnt == STL_LAST)  state_nxt = GAP;
            end
            GAP:       if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE) && !rst;
        wr_ready  = (state == WAIT_DATA);
        busy      = (state != IDLE);
    end

    // tx holds the not-yet-sent bits; pico is always loaded from its LSB at a low-phase start
    always_ff @(posedge iclk) begin
        if (rst) begin
            sclk      <= 1'b0;
            pico      <= 1'b0;
            rd_data   <= 8'h00;
            rd_valid  <= 1'b0;
            err_abort <= 1'b0;
            phase     <= '0;
            high      <= 1'b0;
            bit_idx   <= 3'd0;
            remaining <= 4'd0;
            is_data   <= 1'b0;
            tx        <= 7'd0;
            rx        <= 7'd0;
            stall_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            rd_valid  <= 1'b0;
            err_abort <= 1'b0;
            case (state)
                IDLE: begin
                    sclk <= 1'b0;
                    pico <= 1'b0;
                    if (cmd_valid) begin
                        tx        <= cmd_addr[7:1];
                        pico      <= cmd_addr[0];
                        remaining <= cmd_len;
                        is_data   <= 1'b0;
                        phase     <= '0;
                        high      <= 1'b0;
                        bit_idx   <= 3'd0;
                    end
                end
                SHIFT: begin
                    if (phase != PH_LAST) begin
                        phase <= phase + PW'(1);
                    end else begin
                        phase <= '0;
                        high  <= ~high;
                        sclk  <= ~high;
                        if (high) begin
                            rx      <= {poci, rx[6:1]};
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                pico      <= 1'b0;
                                stall_cnt <= '0;
                                gap_cnt   <= '0;
                                if (is_data) begin
                                    rd_data  <= {poci, rx};
                                    rd_valid <= 1'b1;
                                end
                            end else begin
                                pico <= tx[0];
                                tx   <= {1'b0, tx[6:1]};
                            end
                        end
                    end
                end
                WAIT_DATA: begin
                    if (wr_valid) begin
                        tx      <= wr_data[7:1];
                        pico    <= wr_data[0];
                        is_data <= 1'b1;
                        phase   <= '0;
                        high    <= 1'b0;
                        if (remaining != 4'd0) remaining <= remaining - 4'd1;
                    end else if (stall_cnt == STL_LAST) begin
                        err_abort <= 1'b1;
                        remaining <= 4'd0;
                    end else begin
                        stall_cnt <= stall_cnt + SW'(1);
                    end
                end
                GAP: begin
                    sclk    <= 1'b0;
                    pico    <= 1'b0;
                    gap_cnt <= gap_cnt + GW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_host_driver.sv
// Directed bench for spi_host_driver: write, burst with a late byte, read capture,
// stall abort, mid-frame reset and address-only frames with hand-computed expectations.
module tb_spi_host_driver;

    localparam int CD  = 2;
    localparam int GAP = 16;
    localparam int STL = 8;

    logic       iclk = 1'b0;
    logic       rst, cmd_valid, wr_valid, poci;
    logic [7:0] cmd_addr, wr_data;
    logic [3:0] cmd_len;
    logic       cmd_ready, wr_ready, rd_valid, err_abort, busy, sclk, pico;
    logic [7:0] rd_data;

    spi_host_driver #(.CLK_DIV(CD), .GAP_CYCLES(GAP), .STALL_MAX(STL)) dut (
        .iclk(iclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .err_abort(err_abort),
        .busy(busy), .sclk(sclk), .pico(pico), .poci(poci)
    );

    always #5 iclk = ~iclk;

    int n_vec = 0;
    int n_bad = 0;
    int rises, rdv_cnt, err_cnt, wrr_seen, busy_cyc, low_run, max_low;
    int t_wait, t_err;
    logic [127:0] pico_log;
    logic [7:0]   rd_log [0:15];
    logic [7:0]   wdat   [0:15];
    logic [63:0]  poci_bits;
    logic         sclk_q = 1'b0;

    // observers run on the falling edge, away from the DUT's active edge
    always @(negedge iclk) begin
        if (sclk === 1'b1 && sclk_q === 1'b0) begin
            if (rises < 128) pico_log[rises] = pico;
            rises++;
        end
        sclk_q = sclk;
        if (rd_valid === 1'b1) begin
            if (rdv_cnt < 16) rd_log[rdv_cnt] = rd_data;
            rdv_cnt++;
        end
        if (err_abort === 1'b1) err_cnt++;
        if (wr_ready === 1'b1) wrr_seen++;
        if (busy === 1'b1) busy_cyc++;
        if (busy !== 1'b1) low_run = 0;
        else if (sclk === 1'b0) low_run++;
        else begin
            if (low_run > max_low) max_low = low_run;
            low_run = 0;
        end
    end

    // peripheral model: next poci bit presented on each sclk rise
    always @(posedge sclk) begin
        poci = poci_bits[0];
        poci_bits = poci_bits >> 1;
    end

    task automatic tick;
        @(posedge iclk);
        #1;
    endtask

    task automatic clear_mon;
        rises = 0; rdv_cnt = 0; err_cnt = 0; wrr_seen = 0;
        busy_cyc = 0; low_run = 0; max_low = 0; pico_log = '0;
    endtask

    // Issues one command and feeds data bytes; dur = cycles from accept until cmd_ready returns.
    task automatic do_frame(input logic [7:0] a, input logic [3:0] len, input int dly_byte,
                            input int dly, input bit stall, output int dur);
        int  bi, waitc, t;
        bit  hs, wr_q, done;
        clear_mon();
        bi = 0; waitc = 0; dur = -1; t_wait = -1; t_err = -1; wr_q = 0; done = 0;
        cmd_addr = a; cmd_len = len; cmd_valid = 1'b1; wr_valid = 1'b0;
        tick();
        cmd_valid = 1'b0;
        t = 1;
        while (!done && t < 600) begin
            if (cmd_ready === 1'b1) begin
                dur = t;
                done = 1;
            end else begin
                if (wr_ready === 1'b1 && !wr_q) t_wait = t;
                wr_q = (wr_ready === 1'b1);
                if (err_abort === 1'b1 && t_err < 0) t_err = t;
                wr_data = wdat[bi];
                if (stall && bi >= 1) wr_valid = 1'b0;
                else if (bi == dly_byte && wr_ready === 1'b1 && waitc < dly) begin
                    wr_valid = 1'b0;
                    waitc++;
                end else wr_valid = 1'b1;
                hs = (wr_valid === 1'b1) && (wr_ready === 1'b1);
                tick();
                t++;
                if (hs) bi++;
            end
        end
        wr_valid = 1'b0;
        if (!done) begin
            n_vec++; n_bad++;
            $display("FAIL frame_timeout addr=%h: cmd_ready not back within 600 cycles", a);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 1'b0; wr_valid = 1'b0; cmd_addr = 8'h00;
        cmd_len = 4'd0; wr_data = 8'h00; poci = 1'b0; poci_bits = '0;
        tick(); tick();
        n_vec++;
        if ({sclk, pico, busy, wr_ready, rd_valid, err_abort} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_outs got=%b want=000000", {sclk, pico, busy, wr_ready, rd_valid, err_abort});
        end
        n_vec++;
        if (rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_rd_data got=%h want=00", rd_data); end
        n_vec++;
        if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_ready_in_rst got=%b want=0", cmd_ready); end
        rst = 1'b0;
        #1;
        n_vec++;
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready_after got=%b want=1", cmd_ready); end
    endtask

    task automatic test_write;
        int dur;
        wdat[0] = 8'h03; poci_bits = '0;
        do_frame(8'h02, 4'd1, -1, 0, 1'b0, dur);
        n_vec++; if (dur != 82) begin n_bad++; $display("FAIL write_dur got=%0d want=82", dur); end
        n_vec++; if (rises != 16) begin n_bad++; $display("FAIL write_rises got=%0d want=16", rises); end
        n_vec++; if (pico_log[15:0] !== 16'h0302) begin n_bad++; $display("FAIL write_pico got=%h want=0302", pico_log[15:0]); end
        n_vec++; if (rdv_cnt != 1) begin n_bad++; $display("FAIL write_rdv got=%0d want=1", rdv_cnt); end
        n_vec++; if (max_low != 3) begin n_bad++; $display("FAIL write_max_low got=%0d want=3", max_low); end
        n_vec++; if (busy_cyc != 81) begin n_bad++; $display("FAIL write_busy got=%0d want=81", busy_cyc); end
        n_vec++; if (err_cnt != 0) begin n_bad++; $display("FAIL write_err got=%0d want=0", err_cnt); end
    endtask

    task automatic test_burst;
        int dur;
        wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33;
        poci_bits = 64'h0000_0000_813C_C300;
        do_frame(8'd61, 4'd3, 1, 2, 1'b0, dur);
        n_vec++; if (dur != 150) begin n_bad++; $display("FAIL burst_dur got=%0d want=150", dur); end
        n_vec++; if (rises != 32) begin n_bad++; $display("FAIL burst_rises got=%0d want=32", rises); end
        n_vec++; if (pico_log[31:0] !== 32'h3322113D) begin n_bad++; $display("FAIL burst_pico got=%h want=3322113d", pico_log[31:0]); end
        n_vec++; if (max_low != 5) begin n_bad++; $display("FAIL burst_late_low got=%0d want=5", max_low); end
        n_vec++; if (rdv_cnt != 3) begin n_bad++; $display("FAIL burst_rdv got=%0d want=3", rdv_cnt); end
        n_vec++;
        if ({rd_log[0], rd_log[1], rd_log[2]} !== 24'hC33C81) begin
            n_bad++; $display("FAIL burst_rd got=%h%h%h want=c33c81", rd_log[0], rd_log[1], rd_log[2]);
        end
        n_vec++; if (err_cnt != 0) begin n_bad++; $display("FAIL burst_err got=%0d want=0", err_cnt); end
    endtask

    task automatic test_read;
        int dur;
        wdat[0] = 8'h00;
        poci_bits = 64'h0000_0000_0000_A55A;
        do_frame(8'h10, 4'd1, -1, 0, 1'b0, dur);
        n_vec++; if (rdv_cnt != 1) begin n_bad++; $display("FAIL read_rdv got=%0d want=1", rdv_cnt); end
        n_vec++; if (rd_log[0] !== 8'hA5) begin n_bad++; $display("FAIL read_pulse_data got=%h want=a5", rd_log[0]); end
        n_vec++; if (rd_data !== 8'hA5) begin n_bad++; $display("FAIL read_rd_data got=%h want=a5", rd_data); end
    endtask

    task automatic test_stall;
        int dur;
        wdat[0] = 8'h44; wdat[1] = 8'h55; poci_bits = '0;
        do_frame(8'h20, 4'd2, -1, 0, 1'b1, dur);
        n_vec++; if (err_cnt != 1) begin n_bad++; $display("FAIL stall_err_cnt got=%0d want=1", err_cnt); end
        n_vec++; if (t_err - t_wait != 8) begin n_bad++; $display("FAIL stall_err_delay got=%0d want=8", t_err - t_wait); end
        n_vec++; if (rises != 16) begin n_bad++; $display("FAIL stall_rises got=%0d want=16", rises); end
        n_vec++; if (dur != 90) begin n_bad++; $display("FAIL stall_dur got=%0d want=90", dur); end
        n_vec++; if (pico_log[15:0] !== 16'h4420) begin n_bad++; $display("FAIL stall_pico got=%h want=4420", pico_log[15:0]); end
        n_vec++; if (rdv_cnt != 1) begin n_bad++; $display("FAIL stall_rdv got=%0d want=1", rdv_cnt); end
    endtask

    task automatic test_reset_mid;
        int dur, k;
        clear_mon();
        poci_bits = '0;
        cmd_addr = 8'h7E; cmd_len = 4'd1; wr_data = 8'hAA; wr_valid = 1'b1; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        k = 0;
        while (rises < 5 && k < 100) begin tick(); k++; end
        n_vec++; if (rises < 5) begin n_bad++; $display("FAIL rstmid_reach_bit4 got=%0d rises want=5", rises); end
        rst = 1'b1;
        #1;
        n_vec++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready_in_rst got=%b want=0", cmd_ready); end
        tick();
        rst = 1'b0; wr_valid = 1'b0;
        #1;
        n_vec++;
        if ({sclk, pico, busy, wr_ready} !== 4'b0000) begin
            n_bad++; $display("FAIL rstmid_outs got=%b want=0000", {sclk, pico, busy, wr_ready});
        end
        n_vec++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready got=%b want=1", cmd_ready); end
        repeat (GAP) tick();
        wdat[0] = 8'hFF;
        do_frame(8'h01, 4'd1, -1, 0, 1'b0, dur);
        n_vec++; if (dur != 82) begin n_bad++; $display("FAIL rstmid_next_dur got=%0d want=82", dur); end
        n_vec++; if (pico_log[15:0] !== 16'hFF01) begin n_bad++; $display("FAIL rstmid_next_pico got=%h want=ff01", pico_log[15:0]); end
        n_vec++; if (rdv_cnt != 1) begin n_bad++; $display("FAIL rstmid_next_rdv got=%0d want=1", rdv_cnt); end
    endtask

    task automatic test_addr_only;
        int dur;
        poci_bits = '0;
        do_frame(8'hC3, 4'd0, -1, 0, 1'b0, dur);
        n_vec++; if (rises != 8) begin n_bad++; $display("FAIL addronly_rises got=%0d want=8", rises); end
        n_vec++; if (wrr_seen != 0) begin n_bad++; $display("FAIL addronly_wr_ready got=%0d want=0", wrr_seen); end
        n_vec++; if (rdv_cnt != 0) begin n_bad++; $display("FAIL addronly_rdv got=%0d want=0", rdv_cnt); end
        n_vec++; if (busy_cyc != 48) begin n_bad++; $display("FAIL addronly_busy got=%0d want=48", busy_cyc); end
        n_vec++; if (dur != 49) begin n_bad++; $display("FAIL addronly_dur got=%0d want=49", dur); end
        n_vec++; if (pico_log[7:0] !== 8'hC3) begin n_bad++; $display("FAIL addronly_pico got=%h want=c3", pico_log[7:0]); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_burst();
        test_read();
        test_stall();
        test_reset_mid();
        test_addr_only();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/spi_host_driver.md
# spi_host_driver

Single-clock SPI controller: the initiator for the chip's SPI peripheral. It turns a byte-level command stream (address plus a burst of data bytes) into sclk/PICO waveforms, and captures POCI into read bytes. It sits in the test/FPGA host side of the PSEC5 design and drives the peripheral's serial_in/sclk pins while sampling its serial_out. All serial bytes are LSB-first; the peripheral auto-increments the address across a burst.

## Interface
Parameters:
- CLK_DIV, 4: iclk cycles per sclk half-period (≥1).
- GAP_CYCLES, 16: iclk cycles sclk is held low after each frame, used to trigger the peripheral's sclk-stop reset.
- STALL_MAX, 8: maximum iclk cycles spent waiting for wr_valid at a byte boundary before the frame aborts.

Ports:
- iclk, in, 1: the single clock.
- rst, in, 1: synchronous, active-high reset.
- cmd_valid, in, 1: a command is offered.
- cmd_ready, out, 1: high only in IDLE.
- cmd_addr, in, 8: starting register address.
- cmd_len, in, 4: number of data bytes (0–15). 0 gives an address-only frame.
- wr_data, in, 8: next data byte to send.
- wr_valid, in, 1: wr_data is valid.
- wr_ready, out, 1: high only in WAIT_DATA.
- rd_data, out, 8: byte captured from POCI during the last data byte.
- rd_valid, out, 1: one-cycle pulse when rd_data updates.
- err_abort, out, 1: one-cycle pulse on a stall timeout.
- busy, out, 1: high from the cycle after command accept until GAP ends.
- sclk, out, 1: serial clock. Idles low.
- pico, out, 1: serial data to the peripheral.
- poci, in, 1: serial data from the peripheral.

## Operation
- States: IDLE, SHIFT, WAIT_DATA, GAP.
- IDLE: sclk=0, pico=0, cmd_ready=1. On cmd_valid&cmd_ready:
  - latch cmd_addr into the shift register and cmd_len into the byte counter;
  - set byte type = address;
  - go to SHIFT.
- SHIFT: each bit is a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
  - pico changes only at the start of a low phase.
  - poci is sampled on the last iclk cycle of each high phase into rx_shift[bit_idx].
- After the high phase of bit 7:
  - Data byte: rd_data←rx_shift and rd_valid pulses in the next cycle. Address-byte samples are discarded.
  - If bytes remain: go to WAIT_DATA. Otherwise: go to GAP.
- WAIT_DATA: sclk=0, wr_ready=1.
  - On wr_valid: load wr_data, decrement remaining count, go to SHIFT. The low phase of bit 0 then lasts CLK_DIV more cycles.
  - If STALL_MAX cycles pass without a handshake: pulse err_abort, drop the remaining bytes, go to GAP.
- GAP: sclk=0, pico=0 for GAP_CYCLES cycles, then go to IDLE.
- Counters:
  - phase counter: ceil(log2(CLK_DIV)) bits, wraps each half-period;
  - bit_idx: 3 bits, wraps 7→0;
  - remaining: 4 bits, never underflows.
- rst, mid-frame or otherwise, takes effect at the next edge:
  - state IDLE; sclk=0, pico=0, rd_data=0, rd_valid=0, err_abort=0, busy=0, wr_ready=0;
  - cmd_ready=0 while rst is high, 1 on the first cycle after.
- A partial frame is not completed. The following GAP is skipped; the host must wait ≥GAP_CYCLES before the next command.

## Timing
- Accept at cycle T:
  - pico=cmd_addr[0] from T+1;
  - first sclk rise at T+1+CLK_DIV;
  - address byte occupies T+1 … T+16·CLK_DIV.
- Each data byte with wr_valid already high costs 1+16·CLK_DIV cycles.
- Frame duration with no stalls: 16·CLK_DIV·(1+cmd_len) + cmd_len + GAP_CYCLES cycles after T. cmd_ready reasserts on the next cycle.
- rd_valid for data byte k comes 1 cycle after the bit-7 high phase of that byte.
- cmd_valid during busy is ignored (no handshake). wr_valid outside WAIT_DATA is ignored.
- sclk and pico are registered outputs with no combinational path from inputs.

## Test plan
- Write, CLK_DIV=2, GAP_CYCLES=16: addr=0x02, len=1, wr_data=0x03 held valid.
  - Required: 16 sclk rises; pico bits 0,1,0,0,0,0,0,0 then 1,1,0,0,0,0,0,0.
  - Required: one rd_valid; cmd_ready back at T+82.
- Burst: addr=61, len=3, wr_valid for the second byte delayed 3 cycles.
  - Required: sclk low phase before that byte is 3+2 cycles; 24 data sclk rises; 3 rd_valid pulses; no err_abort.
- Read capture: POCI model updates on sclk rise with 0xA5 LSB-first during the data byte.
  - Required: rd_data=0xA5 with a single rd_valid pulse.
- Stall abort, STALL_MAX=8, len=2: wr_valid never asserted after the first byte.
  - Required: err_abort pulses exactly 8 cycles after entering WAIT_DATA; no further sclk edges; GAP runs; cmd_ready returns.
- Reset mid-frame: rst asserted at bit 4 of the address.
  - Required: next cycle sclk=0, pico=0, busy=0; cmd_ready=1 the cycle after rst drops.
  - Required: a following write of addr=1, data=0xFF completes normally.
- Address-only frame, len=0.
  - Required: exactly 8 sclk rises, no wr_ready, no rd_valid, busy for 16·CLK_DIV+GAP_CYCLES cycles.
